// File: rtl/extbus_ctrl.sv
// Bridges the asynchronous external CPU bus into the clk25 domain: one reg_read or
// reg_write pulse per bus cycle, with read data held on the pads while the read strobe stays low.
module extbus_ctrl #(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk25,
    input  logic              rst_n,
    input  logic              extbus_cs_n,
    input  logic              extbus_rd_n,
    input  logic              extbus_wr_n,
    input  logic [ADDR_W-1:0] extbus_a,
    input  logic [DATA_W-1:0] extbus_d_in,
    output logic [DATA_W-1:0] extbus_d_out,
    output logic              extbus_d_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wrdata,
    output logic              reg_write,
    output logic              reg_read,
    input  logic [DATA_W-1:0] reg_rddata,
    output logic              busy,
    output logic              proto_err
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_ISSUE  = 3'd1,
        RD_DRIVE  = 3'd2,
        WR_ARMED  = 3'd3,
        WR_COMMIT = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] cs_sync, rd_sync, wr_sync;
    logic cs_s, rd_s, wr_s;
    logic rd_act, wr_act;

    logic              err_seen;
    logic              err_cond;
    logic [DATA_W-1:0] d_out_nxt;
    logic              d_oe_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wrdata_nxt;
    logic              write_nxt;
    logic              read_nxt;
    logic              busy_nxt;
    logic              proto_nxt;

    // Synchronizers idle at 1 so a reset never looks like an asserted strobe.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync <= '1;
            rd_sync <= '1;
            wr_sync <= '1;
        end else begin
            cs_sync <= {cs_sync[SYNC_STAGES-2:0], extbus_cs_n};
            rd_sync <= {rd_sync[SYNC_STAGES-2:0], extbus_rd_n};
            wr_sync <= {wr_sync[SYNC_STAGES-2:0], extbus_wr_n};
        end
    end

    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign rd_s   = rd_sync[SYNC_STAGES-1];
    assign wr_s   = wr_sync[SYNC_STAGES-1];
    assign rd_act = !cs_s && !rd_s;
    assign wr_act = !cs_s && !wr_s;

    // State and every output are flops; the comb blocks below only compute next values.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            err_seen     <= 1'b0;
            extbus_d_out <= '0;
            extbus_d_oe  <= 1'b0;
            reg_addr     <= '0;
            reg_wrdata   <= '0;
            reg_write    <= 1'b0;
            reg_read     <= 1'b0;
            busy         <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            state        <= state_nxt;
            err_seen     <= err_cond;
            extbus_d_out <= d_out_nxt;
            extbus_d_oe  <= d_oe_nxt;
            reg_addr     <= addr_nxt;
            reg_wrdata   <= wrdata_nxt;
            reg_write    <= write_nxt;
            reg_read     <= read_nxt;
            busy         <= busy_nxt;
            proto_err    <= proto_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rd_act && !wr_act)
                    state_nxt = RD_ISSUE;
                else if (wr_act && !rd_act)
                    state_nxt = WR_ARMED;
            end
            RD_ISSUE:  state_nxt = RD_DRIVE;
            RD_DRIVE:  if (!rd_act) state_nxt = IDLE;
            WR_ARMED:  if (!wr_act) state_nxt = WR_COMMIT;
            WR_COMMIT: state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        err_cond   = ((state == IDLE) && rd_act && wr_act) ||
                     ((state == RD_DRIVE) && wr_act) ||
                     ((state == WR_ARMED) && rd_act);
        // One pulse per illegal episode, however long the strobes overlap.
        proto_nxt  = err_cond && !err_seen;
        read_nxt   = (state_nxt == RD_ISSUE);
        write_nxt  = (state_nxt == WR_COMMIT);
        busy_nxt   = (state_nxt != IDLE);
        d_oe_nxt   = (state_nxt == RD_DRIVE) && !wr_act;
        addr_nxt   = ((state == IDLE) && (state_nxt != IDLE)) ? extbus_a : reg_addr;
        wrdata_nxt = ((state == WR_ARMED) && wr_act) ? extbus_d_in : reg_wrdata;
        d_out_nxt  = (state == RD_ISSUE) ? reg_rddata : extbus_d_out;
    end

endmodule

// File: tb/tb_extbus_ctrl.sv
// Directed and randomized bus cycles against extbus_ctrl; a transaction-level memory
// model predicts read data and the ordered stream of register accesses.
module tb_extbus_ctrl;
    localparam int ADDR_W      = 5;
    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;

    logic              clk25 = 1'b0;
    logic              rst_n = 1'b0;
    logic              extbus_cs_n = 1'b1;
    logic              extbus_rd_n = 1'b1;
    logic              extbus_wr_n = 1'b1;
    logic [ADDR_W-1:0] extbus_a = '0;
    logic [DATA_W-1:0] extbus_d_in = '0;
    logic [DATA_W-1:0] extbus_d_out;
    logic              extbus_d_oe;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wrdata;
    logic              reg_write;
    logic              reg_read;
    logic [DATA_W-1:0] reg_rddata;
    logic              busy;
    logic              proto_err;

    always #20 clk25 = ~clk25;

    extbus_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk25(clk25), .rst_n(rst_n),
        .extbus_cs_n(extbus_cs_n), .extbus_rd_n(extbus_rd_n), .extbus_wr_n(extbus_wr_n),
        .extbus_a(extbus_a), .extbus_d_in(extbus_d_in),
        .extbus_d_out(extbus_d_out), .extbus_d_oe(extbus_d_oe),
        .reg_addr(reg_addr), .reg_wrdata(reg_wrdata),
        .reg_write(reg_write), .reg_read(reg_read), .reg_rddata(reg_rddata),
        .busy(busy), .proto_err(proto_err)
    );

    // Register file seen by the DUT, and the bench's own idea of what it should hold.
    logic [DATA_W-1:0] tb_regs   [0:31];
    logic [DATA_W-1:0] model_mem [0:31];
    assign reg_rddata = tb_regs[reg_addr];

    int checks   = 0;
    int failures = 0;
    int n_err    = 0;
    int oe_conflict = 0;
    logic [ADDR_W-1:0]        rd_q[$];
    logic [ADDR_W+DATA_W-1:0] wr_q[$];

    always @(negedge clk25) begin
        if (reg_read) rd_q.push_back(reg_addr);
        if (reg_write) begin
            wr_q.push_back({reg_addr, reg_wrdata});
            tb_regs[reg_addr] = reg_wrdata;
        end
        if (proto_err) n_err++;
        if (extbus_d_oe && !extbus_cs_n && !extbus_wr_n) oe_conflict++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk25);
    endtask

    task automatic clear_mon();
        rd_q.delete();
        wr_q.delete();
        n_err = 0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input int hold,
                           output logic [DATA_W-1:0] seen, output logic got);
        extbus_a    = a;
        extbus_cs_n = 1'b0;
        extbus_rd_n = 1'b0;
        got  = 1'b0;
        seen = '0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk25);
            if (extbus_d_oe) begin
                got  = 1'b1;
                seen = extbus_d_out;
            end
        end
        step(hold);
        extbus_rd_n = 1'b1;
        extbus_cs_n = 1'b1;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input int hold);
        extbus_a    = a;
        extbus_d_in = d;
        extbus_cs_n = 1'b0;
        extbus_wr_n = 1'b0;
        step(hold);
        extbus_wr_n = 1'b1;
        extbus_cs_n = 1'b1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DATA_W-1:0]        seen;
        logic                     got;
        logic [ADDR_W-1:0]        exp_rd[$];
        logic [ADDR_W+DATA_W-1:0] exp_wr[$];
        logic [ADDR_W-1:0]        ra;
        logic [DATA_W-1:0]        rd;
        int                       kind;

        for (int i = 0; i < 32; i++) begin
            tb_regs[i]   = 8'($urandom);
            model_mem[i] = tb_regs[i];
        end

        // Reset held with a read strobe already low.
        extbus_a    = 5'h03;
        extbus_cs_n = 1'b0;
        extbus_rd_n = 1'b0;
        step(3);
        check("reset_outputs", 32'({extbus_d_out, extbus_d_oe, reg_addr, reg_wrdata,
                                    reg_write, reg_read, busy, proto_err}), 32'd0);
        rst_n = 1'b1;
        step(1);
        check("post_reset_edge1_read", 32'(reg_read), 32'd0);
        step(1);
        check("post_reset_edge2_read", 32'(reg_read), 32'd0);
        step(1);
        check("post_reset_edge3_read", 32'(reg_read), 32'd1);
        step(2);
        extbus_rd_n = 1'b1;
        extbus_cs_n = 1'b1;
        step(6);
        clear_mon();

        // Directed read a=3 returning 0xA5.
        tb_regs[3]   = 8'hA5;
        model_mem[3] = 8'hA5;
        extbus_a    = 5'h03;
        extbus_cs_n = 1'b0;
        extbus_rd_n = 1'b0;
        step(2);
        check("rd_not_early", 32'(reg_read), 32'd0);
        step(1);
        check("rd_pulse", 32'(reg_read), 32'd1);
        check("rd_addr", 32'(reg_addr), 32'h03);
        check("rd_busy", 32'(busy), 32'd1);
        step(1);
        check("rd_pulse_end", 32'(reg_read), 32'd0);
        check("rd_oe_on", 32'(extbus_d_oe), 32'd1);
        check("rd_dout", 32'(extbus_d_out), 32'hA5);
        step(3);
        check("rd_oe_held", 32'(extbus_d_oe), 32'd1);
        check("rd_dout_held", 32'(extbus_d_out), 32'hA5);
        extbus_rd_n = 1'b1;
        extbus_cs_n = 1'b1;
        step(2);
        check("rd_oe_before_sync", 32'(extbus_d_oe), 32'd1);
        step(1);
        check("rd_oe_off", 32'(extbus_d_oe), 32'd0);
        step(1);
        check("rd_idle_busy", 32'(busy), 32'd0);
        check("rd_single_pulse", 32'(rd_q.size()), 32'd1);
        clear_mon();

        // Directed write a=0x11 d=0x5C with an 8-cycle strobe.
        extbus_a    = 5'h11;
        extbus_d_in = 8'h5C;
        extbus_cs_n = 1'b0;
        extbus_wr_n = 1'b0;
        step(3);
        check("wr_busy", 32'(busy), 32'd1);
        step(5);
        extbus_wr_n = 1'b1;
        extbus_cs_n = 1'b1;
        step(2);
        check("wr_not_early", 32'(reg_write), 32'd0);
        step(1);
        check("wr_pulse", 32'(reg_write), 32'd1);
        check("wr_addr", 32'(reg_addr), 32'h11);
        check("wr_data", 32'(reg_wrdata), 32'h5C);
        check("wr_no_oe", 32'(extbus_d_oe), 32'd0);
        step(1);
        check("wr_pulse_end", 32'(reg_write), 32'd0);
        check("wr_idle_busy", 32'(busy), 32'd0);
        step(4);
        check("wr_single_pulse", 32'(wr_q.size()), 32'd1);
        check("wr_no_read", 32'(rd_q.size()), 32'd0);
        model_mem[5'h11] = 8'h5C;
        clear_mon();

        // Both strobes low together from IDLE.
        extbus_a    = 5'h07;
        extbus_cs_n = 1'b0;
        extbus_rd_n = 1'b0;
        extbus_wr_n = 1'b0;
        step(3);
        check("perr_pulse", 32'(proto_err), 32'd1);
        check("perr_busy", 32'(busy), 32'd0);
        step(1);
        check("perr_pulse_end", 32'(proto_err), 32'd0);
        step(4);
        check("perr_busy_stays", 32'(busy), 32'd0);
        extbus_rd_n = 1'b1;
        extbus_wr_n = 1'b1;
        extbus_cs_n = 1'b1;
        step(5);
        check("perr_no_access", 32'(rd_q.size() + wr_q.size()), 32'd0);
        check("perr_count", 32'(n_err), 32'd1);
        clear_mon();

        // Asynchronous reset while the read data is on the bus.
        extbus_a    = 5'h05;
        extbus_cs_n = 1'b0;
        extbus_rd_n = 1'b0;
        step(4);
        check("arst_oe_before", 32'(extbus_d_oe), 32'd1);
        #5;
        rst_n = 1'b0;
        #1;
        check("arst_oe_drop", 32'(extbus_d_oe), 32'd0);
        check("arst_busy_drop", 32'(busy), 32'd0);
        extbus_rd_n = 1'b1;
        extbus_cs_n = 1'b1;
        step(2);
        clear_mon();
        rst_n = 1'b1;
        step(6);
        check("arst_no_spurious", 32'(rd_q.size() + wr_q.size() + n_err), 32'd0);
        check("arst_idle", 32'(busy), 32'd0);
        clear_mon();

        // Two reads two cycles apart.
        do_read(5'h01, 0, seen, got);
        check("b2b_first_data", 32'(seen), 32'(model_mem[1]));
        step(2);
        do_read(5'h02, 0, seen, got);
        check("b2b_second_data", 32'(seen), 32'(model_mem[2]));
        step(6);
        check("b2b_count", 32'(rd_q.size()), 32'd2);
        ra = (rd_q.size() > 0) ? rd_q[0] : 5'h1F;
        check("b2b_addr0", 32'(ra), 32'h01);
        ra = (rd_q.size() > 1) ? rd_q[1] : 5'h1F;
        check("b2b_addr1", 32'(ra), 32'h02);
        clear_mon();

        // Random mix of reads and writes.
        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 1));
            ra   = 5'($urandom_range(0, 31));
            if (kind == 0) begin
                do_read(ra, int'($urandom_range(0, 3)), seen, got);
                check("rand_rd_oe", 32'(got), 32'd1);
                check("rand_rd_data", 32'(seen), 32'(model_mem[ra]));
                exp_rd.push_back(ra);
            end else begin
                rd = 8'($urandom);
                do_write(ra, rd, int'($urandom_range(2, 8)));
                model_mem[ra] = rd;
                exp_wr.push_back({ra, rd});
            end
            step(int'($urandom_range(3, 5)));
        end
        step(8);
        check("rand_rd_count", 32'(rd_q.size()), 32'(exp_rd.size()));
        check("rand_wr_count", 32'(wr_q.size()), 32'(exp_wr.size()));
        for (int i = 0; i < exp_rd.size(); i++) begin
            ra = (i < rd_q.size()) ? rd_q[i] : ~exp_rd[i];
            check("rand_rd_addr", 32'(ra), 32'(exp_rd[i]));
        end
        for (int i = 0; i < exp_wr.size(); i++) begin
            check("rand_wr_access", 32'((i < wr_q.size()) ? wr_q[i] : ~exp_wr[i]), 32'(exp_wr[i]));
        end
        check("rand_no_perr", 32'(n_err), 32'd0);
        check("oe_never_with_write", 32'(oe_conflict), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
